// File: rtl/count_display_driver.sv
// Binary 0..127 to 3-digit BCD via a sequential double-dabble FSM, driving a
// time-multiplexed common-anode 7-segment display with leading-zero blanking.
module count_display_driver #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  count_in,
   output logic [11:0] bcd_out,
   output logic        conv_busy,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   localparam int unsigned PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t        state_q, state_d;
   logic [6:0]    bin_q, bin_d;
   logic [6:0]    cap_q, cap_d;
   logic [6:0]    last_q, last_d;
   logic [11:0]   acc_q, acc_d;
   logic [11:0]   bcd_q, bcd_d;
   logic [2:0]    iter_q, iter_d;
   logic          force_q, force_d;
   logic          busy_q, busy_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [2:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [11:0]   acc_adj;
   logic [3:0]    nib;
   logic          blank;

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      case (n)
         4'd0:    seg_enc = 7'b1000000;
         4'd1:    seg_enc = 7'b1111001;
         4'd2:    seg_enc = 7'b0100100;
         4'd3:    seg_enc = 7'b0110000;
         4'd4:    seg_enc = 7'b0011001;
         4'd5:    seg_enc = 7'b0010010;
         4'd6:    seg_enc = 7'b0000010;
         4'd7:    seg_enc = 7'b1111000;
         4'd8:    seg_enc = 7'b0000000;
         4'd9:    seg_enc = 7'b0010000;
         default: seg_enc = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      cap_d   = cap_q;
      last_d  = last_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      force_d = force_q;
      acc_adj = acc_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            if (force_q || (count_in != last_q)) begin
               bin_d   = count_in;
               cap_d   = count_in;
               acc_d   = '0;
               iter_d  = 3'd7;
               force_d = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, bin_d} = {acc_adj, bin_q} << 1;
            iter_d = iter_q - 3'd1;
            if (iter_q == 3'd1) state_d = COMMIT;
         end
         COMMIT: begin
            bcd_d   = acc_q;
            last_d  = cap_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT) || (state_d == COMMIT);
   end

   // Display samples the pre-edge index and bcd value, so it lags both by one clock.
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      case (idx_q)
         2'd0: begin
            nib   = bcd_q[3:0];
            blank = 1'b0;
         end
         2'd1: begin
            nib   = bcd_q[7:4];
            blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
         end
         2'd2: begin
            nib   = bcd_q[11:8];
            blank = (bcd_q[11:8] == 4'd0);
         end
         default: begin
            nib   = 4'd0;
            blank = 1'b1;
         end
      endcase
      an_d  = ~(3'b001 << idx_q);
      seg_d = blank ? '1 : seg_enc(nib);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         cap_q   <= '0;
         last_q  <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         force_q <= 1'b1;
         busy_q  <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= '1;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         cap_q   <= cap_d;
         last_q  <= last_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         force_q <= force_d;
         busy_q  <= busy_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign bcd_out   = bcd_q;
   assign conv_busy = busy_q;
   assign an        = an_q;
   assign seg       = seg_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: a cycle-level behavioural model
// predicts captures, commits and the display scan; a monitor checks every clock.
module tb_count_display_driver;

   localparam int unsigned DIV = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
      7'b0010000};

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  count_in = '0;
   logic [11:0] bcd_out;
   logic        conv_busy;
   logic [2:0]  an;
   logic [6:0]  seg;

   int total = 0;
   int bad   = 0;

   count_display_driver #(.SCAN_DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .bcd_out   (bcd_out),
      .conv_busy (conv_busy),
      .an        (an),
      .seg       (seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] exp_seg_for(input int val, input int idx);
      int h, t, u;
      h = val / 100;
      t = (val / 10) % 10;
      u = val % 10;
      if (idx == 0) return SEG_TAB[u];
      if (idx == 1) return (h == 0 && t == 0) ? 7'h7f : SEG_TAB[t];
      return (h == 0) ? 7'h7f : SEG_TAB[h];
   endfunction

   // Reference model: 8 busy clocks follow each capture; commit lands as busy ends.
   int          m_cnt = 0, m_last = 0, m_pend = 0, m_val = 0, m_edges = 0;
   bit          m_force = 1'b1;
   logic [11:0] exp_q[$];
   logic        e_busy = 1'b0;
   logic [2:0]  e_an = 3'b111;
   logic [6:0]  e_seg = 7'h7f;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; m_val = 0; m_force = 1'b1; m_edges = 0;
         exp_q.delete();
         e_busy = 1'b0; e_an = 3'b111; e_seg = 7'h7f;
      end else begin
         int idx;
         idx = (m_edges / DIV) % 3;
         e_an = 3'b111;
         e_an[idx] = 1'b0;
         e_seg = exp_seg_for(m_val, idx);
         m_edges++;
         if (m_cnt == 0) begin
            if (m_force || int'(count_in) != m_last) begin
               exp_q.push_back(to_bcd(int'(count_in)));
               m_pend = int'(count_in);
               m_last = int'(count_in);
               m_force = 1'b0;
               m_cnt = 8;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) m_val = m_pend;
         end
         e_busy = (m_cnt != 0);
      end
   end

   bit          mon_prev_busy = 1'b0;
   logic [11:0] mon_val = '0;

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         chk("rst_an", an, 3'b111);
         chk("rst_seg", seg, 7'h7f);
         chk("rst_bcd", bcd_out, 12'h000);
         chk("rst_busy", conv_busy, 1'b0);
         mon_prev_busy = 1'b0;
         mon_val = '0;
      end else begin
         chk("busy", conv_busy, e_busy);
         if (mon_prev_busy && !conv_busy) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL commit: got %0h expected no commit at %0t", bcd_out, $time);
            end else begin
               mon_val = exp_q.pop_front();
            end
         end
         chk("bcd_out", bcd_out, mon_val);
         chk("an", an, e_an);
         chk("seg", seg, e_seg);
         mon_prev_busy = conv_busy;
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int sweep [7] = '{127, 0, 9, 10, 99, 100, 127};
      int guard;
      rst = 1'b1;
      #1 rst = 1'b0;
      clks(3);
      count_in = 7'd0;
      rst = 1'b1;
      clks(14);
      foreach (sweep[i]) begin
         count_in = 7'(sweep[i]);
         clks(14);
      end
      count_in = 7'd123;
      clks(16);
      count_in = 7'd5;
      clks(4);
      count_in = 7'd77;
      clks(26);
      count_in = 7'd64;
      clks(3);
      rst = 1'b0;
      #1;
      chk("midrst_an", an, 3'b111);
      chk("midrst_seg", seg, 7'h7f);
      chk("midrst_bcd", bcd_out, 12'h000);
      chk("midrst_busy", conv_busy, 1'b0);
      clks(2);
      rst = 1'b1;
      clks(14);
      for (int k = 0; k < 500; k++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 4) count_in = 7'($urandom_range(0, 127));
         else if (r == 19 && $urandom_range(0, 9) == 0) begin
            rst = 1'b0;
            clks(1);
            rst = 1'b1;
         end
         clks(1);
      end
      guard = 0;
      while ((exp_q.size() != 0 || conv_busy) && guard < 50) begin
         clks(1);
         guard++;
      end
      if (guard >= 50) begin
         total++; bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      clks(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
